// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e    - loader FSM states (S_SUM only reachable with PROG_LOADER_CHECKSUM_EN)
//   WORD_BYTES - bytes per header, data word and checksum trailer (little-endian)
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_SUM,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_to_word.sv
// byte_to_word: little-endian shift-in assembler shared by header, data and trailer phases.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset, discards any partial word
//   byte_valid - a byte is accepted this cycle
//   byte_data  - the accepted byte
//   word       - assembled word, valid only while word_valid is high
//   word_valid - combinational pulse on the accept of the last byte of a word
module byte_to_word
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  // Bytes enter at the top and move down, so after three bytes shift_q holds {b2, b1, b0}.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {byte_data, shift_q[23:8]};
    end
  end

  assign word       = {byte_data, shift_q};
  assign word_valid = byte_valid && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader feeding the cpu instruction memory.
// Stream format: 32-bit LE length N, then N LE instruction words (and, when the build defines
// PROG_LOADER_CHECKSUM_EN, a 32-bit LE trailer equal to the mod-2^32 sum of the words).
// The cpu is held in reset until the image is written plus RESET_HOLD cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_data/in_ready - byte stream handshake
//   imem_we/imem_waddr/imem_wdata - imem write port, one pulse per word
//   cpu_reset             - active-high cpu reset
//   done                  - image loaded and cpu released (sticky)
//   error                 - load aborted (sticky)
//   word_count            - words written so far
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = S_SUM;
`else
  localparam state_e AFTER_DATA = S_HOLD;
`endif

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [3:0]            hold_q, hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  logic        accept;
  logic [31:0] word;
  logic        word_valid;

  assign accept = in_valid && in_ready_q;

  byte_to_word u_byte_to_word (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    len_d   = len_q;
    hold_d  = hold_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    unique case (state_q)
      S_LEN: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d = AFTER_DATA;
          end else if (word > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            len_d   = word[ADDR_WIDTH:0];
          end
        end
      end
      S_DATA: begin
        if (word_valid) begin
          we_d    = 1'b1;
          wdata_d = word;
          waddr_d = count_q[ADDR_WIDTH-1:0];
          count_d = count_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
          if (count_d == len_q) state_d = AFTER_DATA;
        end
      end
      S_SUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (word_valid) state_d = (word == sum_q) ? S_HOLD : S_ERR;
`else
        state_d = S_ERR;
`endif
      end
      S_HOLD: begin
        // Counting to RESET_HOLD inclusive puts the release RESET_HOLD+1 edges after entry.
        if (hold_q == 4'(RESET_HOLD)) state_d = S_DONE;
        else                          hold_d  = hold_q + 4'd1;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Outputs are registered from the next state so they change with the state itself.
    in_ready_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_SUM);
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
      len_q       <= '0;
      hold_q      <= 4'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      count_q     <= count_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with an imem-write scoreboard.
// Define PROG_LOADER_CHECKSUM_EN to exercise the checksum trailer build.
module tb_prog_loader;

  localparam int unsigned AW = 11;
  localparam int unsigned RH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  prog_loader #(
    .ADDR_WIDTH (AW),
    .RESET_HOLD (RH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  logic [31:0] mem [0:15];
  int          we_count = 0;
  int          last_we_cyc = 0;
  int          last_acc_cyc = 0;
  int          done_cyc = -1;
  logic        prev_done = 1'b0;

  // Scoreboard: every imem write must match the next expected (address, data) pair.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (imem_we) begin
      we_count++;
      last_we_cyc = cyc;
      if (imem_waddr < 16) mem[imem_waddr[3:0]] = imem_wdata;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, imem_wdata}, 64'hffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_waddr), 64'(e.a));
        check("write_data", 64'(imem_wdata), 64'(e.d));
      end
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int  n = 0;
    bit  took = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!took && n < 100) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (took) last_acc_cyc = cyc;
    else check("byte_accept_timeout", 0, 1);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  // Streams header, img_q words (pushing expected writes) and the trailer when enabled.
  task automatic send_image(input bit gap);
    logic [31:0] sum = 32'd0;
    send_word(32'(img_q.size()), gap);
    for (int i = 0; i < img_q.size(); i++) begin
      exp_q.push_back('{a: AW'(i), d: img_q[i]});
      sum += img_q[i];
      send_word(img_q[i], gap);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum, gap);
`endif
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    in_valid = 1'b0;
    done_cyc = -1;
    @(posedge clk);
    #1;
    check({tag, "_cpu_reset_in_reset"}, 64'(cpu_reset), 1);
    check({tag, "_done_in_reset"}, 64'(done), 0);
    @(posedge clk);
    #1;
    check({tag, "_in_ready_in_reset"}, 64'(in_ready), 0);
    check({tag, "_word_count_in_reset"}, 64'(word_count), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_in_ready_after_reset"}, 64'(in_ready), 1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(done || error)) check("wait_done_timeout", 0, 1);
  endtask

  task automatic check_done(input string tag, input int words);
    check({tag, "_done"}, 64'(done), 1);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 0);
    check({tag, "_error"}, 64'(error), 0);
    check({tag, "_word_count"}, 64'(word_count), 64'(words));
    check({tag, "_release_latency"}, 64'(done_cyc - last_acc_cyc), 64'(RH + 1));
    check({tag, "_writes_pending"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    int base;
    // Reset values while reset is held
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_imem_we", 64'(imem_we), 0);
    @(posedge clk);
    #1;
    check("rst_imem_waddr", 64'(imem_waddr), 0);
    check("rst_imem_wdata", 64'(imem_wdata), 0);
    check("rst_cpu_reset", 64'(cpu_reset), 1);
    check("rst_error", 64'(error), 0);
    do_reset("init");

    // Two-word image, no gaps
    img_q = '{32'h0050_0093, 32'h0000_006F};
    send_image(1'b0);
    wait_end();
    check_done("nogap", 2);
`ifndef PROG_LOADER_CHECKSUM_EN
    check("nogap_we_to_release", 64'(done_cyc - last_we_cyc), 64'(RH + 1));
`endif
    check("nogap_imem1", 64'(mem[1]), 64'h6F);
    check("nogap_imem0", 64'(mem[0]), 64'h0050_0093);
    // Terminal state ignores offered bytes
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("done_sticky", 64'(done), 1);
    check("done_in_ready", 64'(in_ready), 0);

    // Same image with bubbles between every byte; reset from S_DONE first
    do_reset("gap");
    send_image(1'b1);
    wait_end();
    check_done("gap", 2);

    // Empty image
    do_reset("zero");
    base = we_count;
    img_q = {};
    send_image(1'b0);
    wait_end();
    check_done("zero", 0);
    check("zero_no_writes", 64'(we_count - base), 0);

    // Oversize header
    do_reset("big");
    base = we_count;
    send_word(32'd2049, 1'b0);
    in_valid = 1'b0;
    wait_end();
    repeat (RH + 3) @(posedge clk);
    #1;
    check("big_error", 64'(error), 1);
    check("big_in_ready", 64'(in_ready), 0);
    check("big_cpu_reset", 64'(cpu_reset), 1);
    check("big_done", 64'(done), 0);
    check("big_no_writes", 64'(we_count - base), 0);

    // Reset after 5 of 8 data bytes, then a one-word image
    do_reset("mid");
    exp_q.push_back('{a: AW'(0), d: 32'h1122_3344});
    send_word(32'd2, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'h55, 1'b0);
    in_valid = 1'b0;
    do_reset("mid2");
    img_q = '{32'hDEAD_BEEF};
    send_image(1'b0);
    wait_end();
    check_done("mid", 1);
    check("mid_imem0", 64'(mem[0]), 64'hDEAD_BEEF);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good trailer
    do_reset("sum_ok");
    img_q = '{32'h1, 32'h2};
    send_image(1'b0);
    wait_end();
    check_done("sum_ok", 2);

    // Bad trailer: words still written, cpu held in reset
    do_reset("sum_bad");
    exp_q.push_back('{a: AW'(0), d: 32'h1});
    exp_q.push_back('{a: AW'(1), d: 32'h2});
    send_word(32'd2, 1'b0);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h4, 1'b0);
    in_valid = 1'b0;
    wait_end();
    repeat (RH + 3) @(posedge clk);
    #1;
    check("sum_bad_error", 64'(error), 1);
    check("sum_bad_cpu_reset", 64'(cpu_reset), 1);
    check("sum_bad_done", 64'(done), 0);
    check("sum_bad_writes_pending", 64'(exp_q.size()), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
